// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM states, the canonical NOP
// and the default reset vector.
package rv32i_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = '0;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with redirect/increment selection; the pc is
// always word-aligned and the increment wraps modulo 2^32.
module fetch_pc
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        advance,
   output logic [31:0] pc
);

   logic [31:0] pc_d;
   logic [31:0] pc_q;

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (advance) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= {RESET_PC[31:2], 2'b00};
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, registered IF/ID
// outputs, redirect squashes in-flight fetches via the DROP state.
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   output logic        imem_rsp_ready,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4
);

   fetch_state_t state_d, state_q;
   logic         if_valid_d, if_valid_q;
   logic [31:0]  if_inst_d, if_inst_q;
   logic [31:0]  if_pc_d, if_pc_q;
   logic [31:0]  pc;
   logic         advance;
   logic         load;
   logic         req_hs;
   logic         rsp_hs;

   fetch_pc #(
      .RESET_PC (RESET_PC)
   ) u_fetch_pc (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .advance        (advance),
      .pc             (pc)
   );

   // Request is gated by rst_n so it stays low for the whole reset window
   assign imem_req_valid = rst_n && (state_q == REQ);
   assign imem_addr      = {pc[31:2], 2'b00};
   assign imem_rsp_ready = (state_q == WAIT) ? (!if_valid_q || !id_stall)
                                             : (state_q == DROP);
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign rsp_hs         = imem_rsp_valid && imem_rsp_ready;

   always_comb begin
      state_d = state_q;
      advance = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         REQ: begin
            if (redirect_valid) begin
               state_d = req_hs ? DROP : REQ;
            end else if (req_hs) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (redirect_valid) begin
               state_d = rsp_hs ? REQ : DROP;
            end else if (rsp_hs) begin
               load    = 1'b1;
               advance = 1'b1;
               state_d = REQ;
            end
         end
         DROP: begin
            // A response consumed here retires the squashed request even if
            // a further redirect arrives in the same cycle.
            if (rsp_hs) begin
               state_d = REQ;
            end
         end
         default: state_d = REQ;
      endcase
   end

   always_comb begin
      if_inst_d = load ? imem_rsp_data : if_inst_q;
      if_pc_d   = load ? pc : if_pc_q;
      if (redirect_valid) begin
         if_valid_d = 1'b0;
      end else if (load) begin
         if_valid_d = 1'b1;
      end else begin
         if_valid_d = if_valid_q && id_stall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= REQ;
         if_valid_q <= 1'b0;
         if_inst_q  <= INST_NOP;
         if_pc_q    <= RESET_PC;
      end else begin
         state_q    <= state_d;
         if_valid_q <= if_valid_d;
         if_inst_q  <= if_inst_d;
         if_pc_q    <= if_pc_d;
      end
   end

   assign if_valid    = if_valid_q;
   assign if_inst     = if_inst_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_q + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-outstanding imem model that
// answers one cycle after accepting; data word = addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_stall;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;

   logic        rsp_en;
   logic        pend_q;
   logic [31:0] pend_addr_q;

   int unsigned checks;
   int unsigned failures;

   fetch_stage #(
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_stall       (id_stall),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
      end else begin
         if (imem_rsp_valid && imem_rsp_ready) pend_q <= 1'b0;
         if (imem_req_valid && imem_req_ready) begin
            pend_q      <= 1'b1;
            pend_addr_q <= imem_addr;
         end
      end
   end

   assign imem_rsp_valid = pend_q && rsp_en;
   assign imem_rsp_data  = pend_q ? (pend_addr_q ^ 32'hA5A5_0000) : '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      rst_n          = 1'b0;
      imem_req_ready = 1'b1;
      rsp_en         = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_stall       = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_rsp_ready", imem_rsp_ready, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_inst", if_inst, 32'h0000_0013);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_pc_plus4", if_pc_plus4, 32'h4);
      rst_n = 1'b1;
      #1;
      chk("first_req_valid", imem_req_valid, 1);
      chk("first_addr", imem_addr, 32'h0);

      // sequential fetch
      @(negedge clk);
      chk("wait_req_valid", imem_req_valid, 0);
      chk("wait_rsp_ready", imem_rsp_ready, 1);
      chk("wait_if_valid", if_valid, 0);
      @(negedge clk);
      chk("f0_if_valid", if_valid, 1);
      chk("f0_if_inst", if_inst, 32'hA5A5_0000);
      chk("f0_if_pc", if_pc, 32'h0);
      chk("f0_if_pc_plus4", if_pc_plus4, 32'h4);
      chk("f0_next_addr", imem_addr, 32'h4);
      @(negedge clk);
      chk("f0_clear", if_valid, 0);
      @(negedge clk);
      chk("f1_if_valid", if_valid, 1);
      chk("f1_if_inst", if_inst, 32'hA5A5_0004);
      chk("f1_if_pc", if_pc, 32'h4);
      chk("f1_next_addr", imem_addr, 32'h8);

      // decode stall for three cycles
      id_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_if_valid", if_valid, 1);
         chk("stall_if_pc", if_pc, 32'h4);
         chk("stall_if_inst", if_inst, 32'hA5A5_0004);
         chk("stall_rsp_ready", imem_rsp_ready, 0);
      end
      id_stall = 1'b0;
      @(negedge clk);
      chk("post_stall_if_valid", if_valid, 1);
      chk("post_stall_if_pc", if_pc, 32'h8);
      chk("post_stall_if_inst", if_inst, 32'hA5A5_0008);
      chk("post_stall_addr", imem_addr, 32'hC);

      // redirect in WAIT before the response arrives
      rsp_en = 1'b0;
      @(negedge clk);
      chk("w_redir_pre_valid", if_valid, 0);
      chk("w_redir_pre_req", imem_req_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("drop_req_valid", imem_req_valid, 0);
      chk("drop_rsp_ready", imem_rsp_ready, 1);
      chk("drop_if_valid", if_valid, 0);
      rsp_en = 1'b1;
      @(negedge clk);
      chk("drop_stale_if_valid", if_valid, 0);
      chk("redir_req_valid", imem_req_valid, 1);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      @(negedge clk);
      chk("redir_wait_if_valid", if_valid, 0);
      @(negedge clk);
      chk("redir_if_valid", if_valid, 1);
      chk("redir_if_inst", if_inst, 32'hA5A5_0100);
      chk("redir_if_pc", if_pc, 32'h0000_0100);
      chk("redir_next_addr", imem_addr, 32'h0000_0104);

      // redirect coincident with response in WAIT
      @(negedge clk);
      chk("co_rsp_valid", imem_rsp_valid, 1);
      chk("co_rsp_ready", imem_rsp_ready, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("co_if_valid", if_valid, 0);
      chk("co_req_valid", imem_req_valid, 1);
      chk("co_addr", imem_addr, 32'h0000_0200);
      repeat (2) @(negedge clk);
      chk("co_new_if_valid", if_valid, 1);
      chk("co_new_if_inst", if_inst, 32'hA5A5_0200);
      chk("co_new_if_pc", if_pc, 32'h0000_0200);

      // redirect in REQ without handshake, then fetch at the top of memory
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFE;
      @(negedge clk);
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      chk("top_req_valid", imem_req_valid, 1);
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      chk("top_if_valid", if_valid, 0);
      repeat (2) @(negedge clk);
      chk("top_if_valid2", if_valid, 1);
      chk("top_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("top_if_inst", if_inst, 32'h5A5A_FFFC);
      chk("wrap_pc_plus4", if_pc_plus4, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);

      // reset asserted while in WAIT
      @(negedge clk);
      chk("mid_req_valid", imem_req_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_valid", imem_req_valid, 0);
      chk("mid_rst_rsp_ready", imem_rsp_ready, 0);
      chk("mid_rst_if_valid", if_valid, 0);
      chk("mid_rst_if_inst", if_inst, 32'h0000_0013);
      chk("mid_rst_if_pc", if_pc, 32'h0);
      chk("mid_rst_pc_plus4", if_pc_plus4, 32'h4);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("restart_req_valid", imem_req_valid, 1);
      chk("restart_addr", imem_addr, 32'h0);
      repeat (2) @(negedge clk);
      chk("restart_if_valid", if_valid, 1);
      chk("restart_if_inst", if_inst, 32'hA5A5_0000);
      chk("restart_if_pc", if_pc, 32'h0);

      // redirect in REQ coincident with a request handshake
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rq_drop_req_valid", imem_req_valid, 0);
      chk("rq_drop_rsp_ready", imem_rsp_ready, 1);
      chk("rq_drop_if_valid", if_valid, 0);
      @(negedge clk);
      chk("rq_req_valid", imem_req_valid, 1);
      chk("rq_addr", imem_addr, 32'h0000_0300);
      chk("rq_if_valid", if_valid, 0);
      repeat (2) @(negedge clk);
      chk("rq_new_if_valid", if_valid, 1);
      chk("rq_new_if_inst", if_inst, 32'hA5A5_0300);
      chk("rq_new_if_pc", if_pc, 32'h0000_0300);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
